// File: rtl/fan_drive_if.sv
// Fan drive bundle: speed requests, tach and fault control in; PWM drive and status out.
// speed_valid and fault_clear are one-cycle strobes with no ready; the sequencer accepts every strobe.
interface fan_drive_if;
  logic [1:0] requested_speed;
  logic       speed_valid;
  logic       tach_in;
  logic       fault_clear;
  logic       pwm_out;
  logic [6:0] duty_cycle;
  logic [2:0] drive_state;
  logic       fan_fault;

  modport master (
    output requested_speed, speed_valid, tach_in, fault_clear,
    input  pwm_out, duty_cycle, drive_state, fan_fault
  );

  modport slave (
    input  requested_speed, speed_valid, tach_in, fault_clear,
    output pwm_out, duty_cycle, drive_state, fan_fault
  );
endinterface

// File: rtl/fan_drive_sequencer.sv
// Turns 2-bit speed requests into a PWM fan drive with spin-up kick, boundary-aligned
// duty ramping and tach-based stall detection with bounded retries before a latched fault.
module fan_drive_sequencer #(
  parameter int PWM_PERIOD    = 100,
  parameter int DUTY_LOW      = 40,
  parameter int DUTY_MED      = 70,
  parameter int DUTY_HIGH     = 100,
  parameter int RAMP_STEP     = 5,
  parameter int KICK_PERIODS  = 4,
  parameter int STALL_PERIODS = 8,
  parameter int MAX_RETRIES   = 3
) (
  input logic       clk,
  input logic       reset,
  fan_drive_if.slave fan
);

  localparam logic [6:0] PERIOD_LAST = 7'(PWM_PERIOD - 1);
  localparam logic [6:0] FULL_DUTY   = 7'(PWM_PERIOD);
  localparam logic [6:0] STEP        = 7'(RAMP_STEP);
  localparam logic [7:0] KICK_LAST   = 8'(KICK_PERIODS - 1);
  localparam logic [7:0] STALL_LAST  = 8'(STALL_PERIODS - 1);
  localparam logic [7:0] RETRY_LAST  = 8'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KICK  = 3'd1,
    RAMP  = 3'd2,
    RUN   = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t     state, state_nxt, settle_state;
  logic [6:0] pwm_cnt, duty, duty_nxt, target_duty, ramp_duty;
  logic [1:0] target;
  logic [7:0] kick_cnt, kick_nxt, stall_cnt, stall_nxt, retry_cnt, retry_nxt;
  logic       tach_q, tach_q2, tach_sticky, tach_rise, edge_seen;
  logic       boundary, monitor, stall_evt, pwm_q;

  assign boundary  = (pwm_cnt == PERIOD_LAST);
  assign tach_rise = tach_q & ~tach_q2;
  assign edge_seen = tach_sticky | tach_rise;
  assign monitor   = ((state == RAMP) || (state == RUN)) && (target_duty != 7'd0);
  assign stall_evt = monitor && !edge_seen && (stall_cnt == STALL_LAST);

  always_comb begin
    target_duty = 7'd0;
    case (target)
      2'd1:    target_duty = 7'(DUTY_LOW);
      2'd2:    target_duty = 7'(DUTY_MED);
      2'd3:    target_duty = 7'(DUTY_HIGH);
      default: target_duty = 7'd0;
    endcase
  end

  // One ramp step toward the target, clamped so it never overshoots.
  always_comb begin
    ramp_duty = target_duty;
    if ((duty < target_duty) && ((target_duty - duty) > STEP)) ramp_duty = duty + STEP;
    else if ((duty > target_duty) && ((duty - target_duty) > STEP)) ramp_duty = duty - STEP;
    settle_state = RAMP;
    if (ramp_duty == target_duty) settle_state = (target_duty == 7'd0) ? IDLE : RUN;
  end

  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    kick_nxt  = kick_cnt;
    stall_nxt = stall_cnt;
    retry_nxt = retry_cnt;
    if ((state == FAULT) && fan.fault_clear) begin
      state_nxt = IDLE;
      duty_nxt  = 7'd0;
      kick_nxt  = 8'd0;
      stall_nxt = 8'd0;
      retry_nxt = 8'd0;
    end else if (boundary) begin
      if (monitor) stall_nxt = edge_seen ? 8'd0 : stall_cnt + 8'd1;
      else         stall_nxt = 8'd0;
      if (edge_seen && (state == RUN)) retry_nxt = 8'd0;
      case (state)
        IDLE: begin
          duty_nxt = 7'd0;
          if (target_duty != 7'd0) begin
            state_nxt = KICK;
            duty_nxt  = FULL_DUTY;
            kick_nxt  = 8'd0;
          end
        end
        KICK: begin
          if (kick_cnt == KICK_LAST) begin
            duty_nxt  = ramp_duty;
            state_nxt = settle_state;
          end else begin
            kick_nxt = kick_cnt + 8'd1;
          end
        end
        RAMP, RUN: begin
          if (stall_evt) begin
            retry_nxt = retry_cnt + 8'd1;
            stall_nxt = 8'd0;
            if (retry_cnt == RETRY_LAST) begin
              state_nxt = FAULT;
              duty_nxt  = 7'd0;
            end else begin
              state_nxt = KICK;
              duty_nxt  = FULL_DUTY;
              kick_nxt  = 8'd0;
            end
          end else begin
            duty_nxt  = ramp_duty;
            state_nxt = settle_state;
          end
        end
        FAULT:   duty_nxt = 7'd0;
        default: begin
          state_nxt = IDLE;
          duty_nxt  = 7'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      duty        <= 7'd0;
      pwm_cnt     <= 7'd0;
      target      <= 2'd0;
      kick_cnt    <= 8'd0;
      stall_cnt   <= 8'd0;
      retry_cnt   <= 8'd0;
      tach_q      <= 1'b0;
      tach_q2     <= 1'b0;
      tach_sticky <= 1'b0;
      pwm_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      duty        <= duty_nxt;
      kick_cnt    <= kick_nxt;
      stall_cnt   <= stall_nxt;
      retry_cnt   <= retry_nxt;
      pwm_cnt     <= boundary ? 7'd0 : pwm_cnt + 7'd1;
      if (fan.speed_valid) target <= fan.requested_speed;
      tach_q      <= fan.tach_in;
      tach_q2     <= tach_q;
      tach_sticky <= boundary ? 1'b0 : (tach_sticky | tach_rise);
      // Drive is forced low the moment FAULT is entered, not one period later.
      pwm_q       <= (pwm_cnt < duty) && (state_nxt != FAULT);
    end
  end

  assign fan.pwm_out     = pwm_q;
  assign fan.duty_cycle  = duty;
  assign fan.drive_state = state;
  assign fan.fan_fault   = (state == FAULT);

endmodule

// File: tb/tb_fan_drive_sequencer.sv
// Self-checking bench for fan_drive_sequencer: directed scenarios against hand-derived
// constants plus a randomized run against a period-level behavioural model.
module tb_fan_drive_sequencer;

  localparam int P       = 100;
  localparam int D_LOW   = 40;
  localparam int D_MED   = 70;
  localparam int D_HIGH  = 100;
  localparam int STEP    = 5;
  localparam int KICK_N  = 4;
  localparam int STALL_N = 8;
  localparam int MAX_RT  = 3;

  localparam int S_IDLE = 0, S_KICK = 1, S_RAMP = 2, S_RUN = 3, S_FAULT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fan_drive_if bus ();

  fan_drive_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .fan   (bus)
  );

  int vec = 0;
  int err = 0;
  int cyc = 0;
  int tach_mode = 0;
  logic tach_lvl = 1'b0;

  // Reference model state (integers, updated once per clock)
  int m_cnt = 0, m_tgt = 0, m_duty = 0, m_state = 0, m_kick = 0, m_stall = 0, m_retry = 0, m_pwm = 0;
  bit m_t1 = 0, m_t2 = 0, m_sticky = 0;

  function automatic int duty_of(int s);
    case (s)
      1: return D_LOW;
      2: return D_MED;
      3: return D_HIGH;
      default: return 0;
    endcase
  endfunction

  function automatic int toward(int d, int t);
    int diff;
    diff = t - d;
    if (diff > STEP) diff = STEP;
    if (diff < -STEP) diff = -STEP;
    return d + diff;
  endfunction

  function automatic int settle(int d, int t);
    if (d != t) return S_RAMP;
    return (t == 0) ? S_IDLE : S_RUN;
  endfunction

  task automatic model_step();
    int td, nd, ns;
    bit bnd, rise, seen, stalled;
    if (reset) begin
      m_cnt = 0; m_tgt = 0; m_duty = 0; m_state = 0; m_kick = 0; m_stall = 0;
      m_retry = 0; m_pwm = 0; m_t1 = 0; m_t2 = 0; m_sticky = 0;
      return;
    end
    bnd  = (m_cnt == P - 1);
    rise = m_t1 && !m_t2;
    seen = m_sticky || rise;
    td = duty_of(m_tgt);
    ns = m_state;
    nd = m_duty;
    if (bus.fault_clear && m_state == S_FAULT) begin
      ns = S_IDLE; nd = 0; m_kick = 0; m_stall = 0; m_retry = 0;
    end else if (bnd) begin
      stalled = 0;
      if ((m_state == S_RAMP || m_state == S_RUN) && td != 0) begin
        if (seen) m_stall = 0;
        else begin
          m_stall++;
          stalled = (m_stall == STALL_N);
        end
      end else m_stall = 0;
      if (seen && m_state == S_RUN) m_retry = 0;
      if (m_state == S_IDLE) begin
        if (td != 0) begin ns = S_KICK; nd = P; m_kick = 0; end
      end else if (m_state == S_KICK) begin
        m_kick++;
        if (m_kick == KICK_N) begin nd = toward(P, td); ns = settle(nd, td); end
      end else if (m_state == S_RAMP || m_state == S_RUN) begin
        if (stalled) begin
          m_retry++;
          m_stall = 0;
          if (m_retry == MAX_RT) begin ns = S_FAULT; nd = 0; end
          else begin ns = S_KICK; nd = P; m_kick = 0; end
        end else begin
          nd = toward(m_duty, td);
          ns = settle(nd, td);
        end
      end
    end
    m_pwm = (m_cnt < m_duty && ns != S_FAULT) ? 1 : 0;
    m_sticky = bnd ? 0 : (m_sticky || rise);
    m_t2 = m_t1;
    m_t1 = bus.tach_in;
    if (bus.speed_valid) m_tgt = int'(bus.requested_speed);
    m_cnt = bnd ? 0 : m_cnt + 1;
    m_state = ns;
    m_duty = nd;
  endtask

  // One clock: drive tach, let the edge happen, advance the model, return on the falling edge.
  task automatic cycle();
    case (tach_mode)
      0: bus.tach_in = 1'b0;
      1: bus.tach_in = ((cyc % 50) < 25);
      2: if ($urandom_range(0, 19) == 0) bus.tach_in = ~bus.tach_in;
      default: bus.tach_in = tach_lvl;
    endcase
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_boundary();
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (m_cnt != 0 && n <= P + 1);
    if (m_cnt != 0) begin
      vec++; err++;
      $display("FAIL boundary_timeout cycles=%0d required <=%0d", n, P);
    end
  endtask

  task automatic strobe(int s);
    bus.requested_speed = 2'(s);
    bus.speed_valid = 1'b1;
    cycle();
    bus.speed_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.speed_valid = 1'b0;
    bus.fault_clear = 1'b0;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int hi;
    do_reset();
    vec++;
    if (bus.pwm_out !== 1'b0 || bus.duty_cycle !== 7'd0 || bus.drive_state !== 3'd0 || bus.fan_fault !== 1'b0) begin
      err++;
      $display("FAIL reset_outputs pwm=%b duty=%0d state=%0d fault=%b required 0/0/0/0",
               bus.pwm_out, bus.duty_cycle, bus.drive_state, bus.fan_fault);
    end
    hi = 0;
    repeat (P) begin cycle(); hi += int'(bus.pwm_out); end
    vec++;
    if (hi != 0 || bus.drive_state !== 3'd0) begin
      err++;
      $display("FAIL reset_idle_quiet pwm_high=%0d state=%0d required 0/0", hi, bus.drive_state);
    end
  endtask

  task automatic test_spinup();
    int hi, exp_d, exp_s;
    tach_mode = 1;
    strobe(1);
    for (int k = 1; k <= 16; k++) begin
      wait_boundary();
      exp_d = (k <= KICK_N) ? P : P - STEP * (k - KICK_N);
      exp_s = (k <= KICK_N) ? S_KICK : ((k < 16) ? S_RAMP : S_RUN);
      vec++;
      if (int'(bus.duty_cycle) != exp_d || int'(bus.drive_state) != exp_s) begin
        err++;
        $display("FAIL spinup period=%0d duty=%0d state=%0d required %0d/%0d",
                 k, bus.duty_cycle, bus.drive_state, exp_d, exp_s);
      end
    end
    wait_boundary();
    hi = 0;
    repeat (P) begin cycle(); hi += int'(bus.pwm_out); end
    vec++;
    if (hi != D_LOW) begin
      err++;
      $display("FAIL spinup_pwm_high got=%0d required=%0d", hi, D_LOW);
    end
  endtask

  task automatic test_ramp();
    int hi, exp_d, exp_s;
    wait_boundary();
    strobe(2);
    for (int k = 1; k <= 6; k++) begin
      wait_boundary();
      exp_d = D_LOW + STEP * k;
      exp_s = (k < 6) ? S_RAMP : S_RUN;
      vec++;
      if (int'(bus.duty_cycle) != exp_d || int'(bus.drive_state) != exp_s) begin
        err++;
        $display("FAIL ramp_up step=%0d duty=%0d state=%0d required %0d/%0d",
                 k, bus.duty_cycle, bus.drive_state, exp_d, exp_s);
      end
    end
    strobe(0);
    for (int k = 1; k <= 14; k++) begin
      wait_boundary();
      exp_d = D_MED - STEP * k;
      exp_s = (k < 14) ? S_RAMP : S_IDLE;
      vec++;
      if (int'(bus.duty_cycle) != exp_d || int'(bus.drive_state) != exp_s) begin
        err++;
        $display("FAIL ramp_down step=%0d duty=%0d state=%0d required %0d/%0d",
                 k, bus.duty_cycle, bus.drive_state, exp_d, exp_s);
      end
    end
    hi = 0;
    repeat (P) begin cycle(); hi += int'(bus.pwm_out); end
    vec++;
    if (hi != 0) begin
      err++;
      $display("FAIL ramp_off_pwm got=%0d required=0", hi);
    end
  endtask

  task automatic test_stall_fault();
    int kicks, fault_at, prev, hi;
    do_reset();
    tach_mode = 0;
    strobe(3);
    kicks = 0; fault_at = 0; prev = S_IDLE;
    for (int k = 1; k <= 45 && fault_at == 0; k++) begin
      wait_boundary();
      if (int'(bus.drive_state) == S_KICK && prev != S_KICK) kicks++;
      if (int'(bus.drive_state) == S_FAULT) fault_at = k;
      prev = int'(bus.drive_state);
    end
    vec++;
    if (fault_at != 37 || kicks != 3) begin
      err++;
      $display("FAIL stall_sequence fault_period=%0d kicks=%0d required 37/3", fault_at, kicks);
    end
    hi = 0;
    repeat (50) begin cycle(); hi += int'(bus.pwm_out); end
    vec++;
    if (bus.fan_fault !== 1'b1 || bus.duty_cycle !== 7'd0 || hi != 0) begin
      err++;
      $display("FAIL fault_outputs fault=%b duty=%0d pwm_high=%0d required 1/0/0", bus.fan_fault, bus.duty_cycle, hi);
    end
    bus.fault_clear = 1'b1;
    cycle();
    bus.fault_clear = 1'b0;
    vec++;
    if (bus.drive_state !== 3'd0 || bus.fan_fault !== 1'b0 || bus.duty_cycle !== 7'd0) begin
      err++;
      $display("FAIL fault_clear state=%0d fault=%b duty=%0d required 0/0/0", bus.drive_state, bus.fan_fault, bus.duty_cycle);
    end
    wait_boundary();
    vec++;
    if (bus.drive_state !== 3'd1 || int'(bus.duty_cycle) != P) begin
      err++;
      $display("FAIL rekick state=%0d duty=%0d required 1/%0d", bus.drive_state, bus.duty_cycle, P);
    end
    bus.fault_clear = 1'b1;
    cycle();
    bus.fault_clear = 1'b0;
    vec++;
    if (bus.drive_state !== 3'd1) begin
      err++;
      $display("FAIL clear_ignored state=%0d required 1", bus.drive_state);
    end
  endtask

  task automatic test_boundary_strobe();
    int n;
    do_reset();
    tach_mode = 1;
    strobe(1);
    repeat (16) wait_boundary();
    n = 0;
    while (m_cnt != P - 1 && n < P) begin cycle(); n++; end
    bus.requested_speed = 2'd3;
    bus.speed_valid = 1'b1;
    cycle();
    bus.speed_valid = 1'b0;
    vec++;
    if (int'(bus.duty_cycle) != D_LOW || bus.drive_state !== 3'd3) begin
      err++;
      $display("FAIL strobe_on_boundary duty=%0d state=%0d required %0d/3", bus.duty_cycle, bus.drive_state, D_LOW);
    end
    wait_boundary();
    vec++;
    if (int'(bus.duty_cycle) != D_LOW + STEP || bus.drive_state !== 3'd2) begin
      err++;
      $display("FAIL strobe_next_period duty=%0d state=%0d required %0d/2", bus.duty_cycle, bus.drive_state, D_LOW + STEP);
    end
  endtask

  task automatic test_edge_vs_stall();
    int n;
    do_reset();
    tach_mode = 0;
    strobe(3);
    repeat (KICK_N + 1) wait_boundary();
    repeat (STALL_N - 1) wait_boundary();
    vec++;
    if (bus.drive_state !== 3'd3) begin
      err++;
      $display("FAIL pre_stall_run state=%0d required 3", bus.drive_state);
    end
    n = 0;
    while (m_cnt != 80 && n < P) begin cycle(); n++; end
    tach_mode = 3;
    tach_lvl = 1'b1;
    repeat (5) cycle();
    tach_lvl = 1'b0;
    wait_boundary();
    vec++;
    if (bus.drive_state !== 3'd3) begin
      err++;
      $display("FAIL edge_beats_stall state=%0d required 3", bus.drive_state);
    end
    repeat (STALL_N - 1) wait_boundary();
    vec++;
    if (bus.drive_state !== 3'd3) begin
      err++;
      $display("FAIL stall_counter_cleared state=%0d required 3", bus.drive_state);
    end
    wait_boundary();
    vec++;
    if (bus.drive_state !== 3'd1) begin
      err++;
      $display("FAIL stall_after_clear state=%0d required 1", bus.drive_state);
    end
  endtask

  task automatic test_reset_mid_ramp();
    int act;
    do_reset();
    tach_mode = 1;
    strobe(1);
    repeat (13) wait_boundary();
    vec++;
    if (int'(bus.duty_cycle) != 55 || bus.drive_state !== 3'd2) begin
      err++;
      $display("FAIL mid_ramp_setup duty=%0d state=%0d required 55/2", bus.duty_cycle, bus.drive_state);
    end
    repeat (30) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    vec++;
    if (bus.pwm_out !== 1'b0 || bus.duty_cycle !== 7'd0 || bus.drive_state !== 3'd0 || bus.fan_fault !== 1'b0) begin
      err++;
      $display("FAIL reset_mid_ramp pwm=%b duty=%0d state=%0d fault=%b required 0/0/0/0",
               bus.pwm_out, bus.duty_cycle, bus.drive_state, bus.fan_fault);
    end
    act = 0;
    repeat (3 * P) begin
      cycle();
      act += int'(bus.pwm_out) + int'(bus.duty_cycle) + int'(bus.drive_state);
    end
    vec++;
    if (act != 0) begin
      err++;
      $display("FAIL post_reset_quiet activity=%0d required 0", act);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 12000; i++) begin
      tach_mode = (((i / 2000) % 3) == 1) ? 0 : 2;
      bus.speed_valid = ($urandom_range(0, 399) == 0);
      bus.requested_speed = 2'($urandom_range(0, 3));
      bus.fault_clear = ($urandom_range(0, 299) == 0);
      cycle();
      vec++;
      if (int'(bus.pwm_out) != m_pwm || int'(bus.duty_cycle) != m_duty ||
          int'(bus.drive_state) != m_state || int'(bus.fan_fault) != int'(m_state == S_FAULT)) begin
        err++;
        if (err < 30)
          $display("FAIL random cycle=%0d pwm=%b duty=%0d state=%0d fault=%b required %0d/%0d/%0d/%0d",
                   i, bus.pwm_out, bus.duty_cycle, bus.drive_state, bus.fan_fault,
                   m_pwm, m_duty, m_state, int'(m_state == S_FAULT));
      end
    end
    bus.speed_valid = 1'b0;
    bus.fault_clear = 1'b0;
  endtask

  initial begin
    bus.requested_speed = 2'd0;
    bus.speed_valid = 1'b0;
    bus.tach_in = 1'b0;
    bus.fault_clear = 1'b0;
    @(negedge clk);
    test_reset();
    test_spinup();
    test_ramp();
    test_stall_fault();
    test_boundary_strobe();
    test_edge_vs_stall();
    test_reset_mid_ramp();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
